// File: rtl/amem_ctl_byp_if.sv
// A-memory control bundle: sequencer strobes, instruction register and write
// data toward the controller, and the resulting addresses, pulses and bypass
// result back toward the datapath.
//   master : drives strobes/ir/dest/destm/l/inval, observes addresses/pulses/bypass
//   slave  : the controller side (amem_ctl_byp)
interface amem_ctl_byp_if #(
  parameter int unsigned AW  = 10,
  parameter int unsigned IRW = 49,
  parameter int unsigned DW  = 32
);
  logic           state_decode;
  logic           state_write;
  logic [IRW-1:0] ir;
  logic           dest;
  logic           destm;
  logic [DW-1:0]  l;
  logic           inval;
  logic [AW-1:0]  aadr;
  logic [AW-1:0]  wadr;
  logic           arp;
  logic           awp;
  logic           abyp;
  logic [DW-1:0]  abyp_data;

  modport master (
    output state_decode, state_write, ir, dest, destm, l, inval,
    input  aadr, wadr, arp, awp, abyp, abyp_data
  );

  modport slave (
    input  state_decode, state_write, ir, dest, destm, l, inval,
    output aadr, wadr, arp, awp, abyp, abyp_data
  );
endinterface

// File: rtl/amem_ctl_byp.sv
// A-memory control with last-write bypass.
// Derives A-memory read/write addresses and pulses from the instruction
// register and sequencer strobes, and forwards the most recent write to a
// following read of the same location (hides the sync-RAM RAW hazard).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : amem_ctl_byp_if slave (strobes, ir, dest/destm, l, inval in;
//           aadr, wadr, arp, awp, abyp, abyp_data out)
module amem_ctl_byp #(
  parameter int unsigned AW       = 10,
  parameter int unsigned MW       = 5,
  parameter int unsigned IRW      = 49,
  parameter int unsigned DW       = 32,
  parameter int unsigned ASRC_LSB = 32,
  parameter int unsigned ADST_LSB = 14,
  parameter int unsigned BYPASS   = 1
) (
  input logic           clk,
  input logic           reset,
  amem_ctl_byp_if.slave bus
);

  logic [IRW-1:0] ir_c;
  logic [AW-1:0]  src_c;
  logic [AW-1:0]  dst_c;
  logic           arp_c;
  logic           awp_c;
  logic           unused_ir;

  logic [AW-1:0]  wadr_q;
  logic [AW-1:0]  lw_addr_q;
  logic [DW-1:0]  lw_data_q;
  logic           lw_valid_q;

  // Field extraction; M destinations are short and zero-extended.
  assign ir_c      = bus.ir;
  assign unused_ir = ^ir_c;
  assign src_c     = ir_c[ASRC_LSB +: AW];
  assign dst_c     = bus.destm ? AW'(ir_c[ADST_LSB +: MW]) : ir_c[ADST_LSB +: AW];

  // Strobes; write address wins the shared address port on a collision.
  assign awp_c = bus.dest & bus.state_write;
  assign arp_c = bus.state_decode & ~bus.state_write;

  assign bus.awp  = awp_c;
  assign bus.arp  = arp_c;
  assign bus.aadr = bus.state_write ? wadr_q : src_c;
  assign bus.wadr = wadr_q;

  // Destination address latched at DECODE for use in the later WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wadr_q <= '0;
    end else if (bus.state_decode) begin
      wadr_q <= dst_c;
    end
  end

  // Last-write record; a write in the same cycle beats an invalidate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lw_addr_q  <= '0;
      lw_data_q  <= '0;
      lw_valid_q <= 1'b0;
    end else if (awp_c) begin
      lw_addr_q  <= wadr_q;
      lw_data_q  <= bus.l;
      lw_valid_q <= 1'b1;
    end else if (bus.inval) begin
      lw_valid_q <= 1'b0;
    end
  end

  // Bypass select/data, one cycle after the read pulse like the RAM output.
  if (BYPASS != 0) begin : g_byp
    logic          abyp_q;
    logic [DW-1:0] abyp_data_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        abyp_q      <= 1'b0;
        abyp_data_q <= '0;
      end else if (arp_c) begin
        abyp_q      <= lw_valid_q && (src_c == lw_addr_q);
        abyp_data_q <= lw_data_q;
      end else begin
        abyp_q      <= 1'b0;
      end
    end

    assign bus.abyp      = abyp_q;
    assign bus.abyp_data = abyp_data_q;
  end else begin : g_nobyp
    assign bus.abyp      = 1'b0;
    assign bus.abyp_data = '0;
  end

endmodule

// File: tb/tb_amem_ctl_byp.sv
// Self-checking bench for amem_ctl_byp: scoreboard of expected bypass
// results pushed at stimulus time and popped one edge later, plus inline
// checks of the combinational strobes and latched addresses.
module tb_amem_ctl_byp;

  logic clk;
  logic reset;

  amem_ctl_byp_if #(.AW(10), .IRW(49), .DW(32)) bus ();

  amem_ctl_byp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        byp;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [9:0]  m_wadr;
  logic [9:0]  m_lw_addr;
  logic [31:0] m_lw_data;
  logic        m_lw_valid;
  logic [31:0] m_byp_data;

  task automatic model_reset();
    m_wadr     = '0;
    m_lw_addr  = '0;
    m_lw_data  = '0;
    m_lw_valid = 1'b0;
    m_byp_data = '0;
    sbq.delete();
  endtask

  task automatic drive(input logic dec, input logic wr, input logic [9:0] src,
                       input logic [9:0] dst, input logic dm, input logic de,
                       input logic [31:0] ld, input logic inv);
    logic [48:0] v;
    v = {17'($urandom), 32'($urandom)};
    v[41:32] = src;
    v[23:14] = dst;
    bus.state_decode = dec;
    bus.state_write  = wr;
    bus.ir           = v;
    bus.destm        = dm;
    bus.dest         = de;
    bus.l            = ld;
    bus.inval        = inv;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Advance one edge: model predicts, scoreboard pops and compares.
  task automatic step();
    exp_t        e;
    exp_t        got;
    logic [9:0]  src;
    logic [9:0]  dst;
    logic        arp;
    logic        awp;
    src = bus.ir[41:32];
    dst = bus.destm ? {5'b0, bus.ir[18:14]} : bus.ir[23:14];
    arp = bus.state_decode & ~bus.state_write;
    awp = bus.dest & bus.state_write;
    if (arp) begin
      e.byp      = m_lw_valid && (src == m_lw_addr);
      e.data     = m_lw_data;
      m_byp_data = m_lw_data;
    end else begin
      e.byp  = 1'b0;
      e.data = m_byp_data;
    end
    sbq.push_back(e);
    if (awp) begin
      m_lw_addr  = m_wadr;
      m_lw_data  = bus.l;
      m_lw_valid = 1'b1;
    end else if (bus.inval) begin
      m_lw_valid = 1'b0;
    end
    if (bus.state_decode) m_wadr = dst;
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    n_tests++;
    if (bus.abyp !== got.byp) begin
      n_fail++;
      $display("FAIL sb_abyp: got %b expected %b", bus.abyp, got.byp);
    end
    n_tests++;
    if (bus.abyp_data !== got.data) begin
      n_fail++;
      $display("FAIL sb_abyp_data: got %h expected %h", bus.abyp_data, got.data);
    end
    n_tests++;
    if (bus.wadr !== m_wadr) begin
      n_fail++;
      $display("FAIL sb_wadr: got %h expected %h", bus.wadr, m_wadr);
    end
  endtask

  task automatic test_reset();
    logic dec, wr, de;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dec = 1'($urandom);
      wr  = 1'($urandom);
      de  = 1'($urandom);
      drive(dec, wr, 10'($urandom), 10'($urandom), 1'b0, de, 32'($urandom), 1'b0);
      #1;
      n_tests++;
      if (bus.awp !== (de & wr)) begin
        n_fail++;
        $display("FAIL rst_awp: got %b expected %b", bus.awp, de & wr);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.wadr !== 10'h000 || bus.abyp !== 1'b0 || bus.abyp_data !== 32'h0) begin
        n_fail++;
        $display("FAIL rst_regs: got wadr=%h abyp=%b data=%h expected 0/0/0",
                 bus.wadr, bus.abyp, bus.abyp_data);
      end
    end
    idle();
    reset = 1'b1;
    model_reset();
    drive(1'b1, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    n_tests++;
    if (bus.abyp !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_first_decode: got abyp=%b expected 0", bus.abyp);
    end
  endtask

  task automatic test_addr_select();
    drive(1'b1, 1'b0, 10'h155, 10'h2A3, 1'b0, 1'b1, 32'h0, 1'b0);
    #1;
    n_tests++;
    if (bus.aadr !== 10'h155 || bus.arp !== 1'b1 || bus.awp !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_decode: got aadr=%h arp=%b awp=%b expected 155/1/0",
               bus.aadr, bus.arp, bus.awp);
    end
    step();
    n_tests++;
    if (bus.wadr !== 10'h2A3) begin
      n_fail++;
      $display("FAIL addr_wadr: got %h expected 2a3", bus.wadr);
    end
    drive(1'b0, 1'b1, 10'h155, 10'h000, 1'b0, 1'b1, 32'h1111_2222, 1'b0);
    #1;
    n_tests++;
    if (bus.aadr !== 10'h2A3 || bus.awp !== 1'b1 || bus.arp !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_write: got aadr=%h awp=%b arp=%b expected 2a3/1/0",
               bus.aadr, bus.awp, bus.arp);
    end
    drive(1'b0, 1'b1, 10'h155, 10'h000, 1'b0, 1'b0, 32'h3333_4444, 1'b0);
    #1;
    n_tests++;
    if (bus.awp !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_nodest: got awp=%b expected 0", bus.awp);
    end
    step();
    idle();
    step();
  endtask

  task automatic test_m_dest();
    drive(1'b1, 1'b0, 10'h000, 10'h3F7, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    n_tests++;
    if (bus.wadr !== 10'h017) begin
      n_fail++;
      $display("FAIL m_dest: got wadr=%h expected 017", bus.wadr);
    end
    idle();
    step();
  endtask

  task automatic test_forward();
    drive(1'b1, 1'b0, 10'h000, 10'h040, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b1, 10'h000, 10'h000, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    step();
    drive(1'b1, 1'b0, 10'h040, 10'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    n_tests++;
    if (bus.abyp !== 1'b1 || bus.abyp_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL fwd_hit: got abyp=%b data=%h expected 1/deadbeef",
               bus.abyp, bus.abyp_data);
    end
    drive(1'b1, 1'b0, 10'h041, 10'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    n_tests++;
    if (bus.abyp !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_miss: got abyp=%b expected 0", bus.abyp);
    end
    idle();
    step();
  endtask

  task automatic test_inval();
    drive(1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    drive(1'b1, 1'b0, 10'h040, 10'h040, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    n_tests++;
    if (bus.abyp !== 1'b0) begin
      n_fail++;
      $display("FAIL inval_alone: got abyp=%b expected 0", bus.abyp);
    end
    // Write and invalidate together: the write wins.
    drive(1'b0, 1'b1, 10'h000, 10'h000, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
    step();
    // Invalidate alongside the read must not affect this comparison.
    drive(1'b1, 1'b0, 10'h040, 10'h000, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    n_tests++;
    if (bus.abyp !== 1'b1 || bus.abyp_data !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL inval_prio: got abyp=%b data=%h expected 1/cafef00d",
               bus.abyp, bus.abyp_data);
    end
    drive(1'b1, 1'b0, 10'h040, 10'h000, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    n_tests++;
    if (bus.abyp !== 1'b0 || bus.abyp_data !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL inval_after: got abyp=%b data=%h expected 0/cafef00d",
               bus.abyp, bus.abyp_data);
    end
    idle();
    step();
  endtask

  task automatic test_collision();
    drive(1'b1, 1'b0, 10'h000, 10'h123, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b1, 1'b1, 10'h055, 10'h0AA, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
    #1;
    n_tests++;
    if (bus.arp !== 1'b0 || bus.awp !== 1'b1 || bus.aadr !== 10'h123) begin
      n_fail++;
      $display("FAIL coll_comb: got arp=%b awp=%b aadr=%h expected 0/1/123",
               bus.arp, bus.awp, bus.aadr);
    end
    step();
    n_tests++;
    if (bus.abyp !== 1'b0 || bus.wadr !== 10'h0AA) begin
      n_fail++;
      $display("FAIL coll_regs: got abyp=%b wadr=%h expected 0/0aa", bus.abyp, bus.wadr);
    end
    // The collision write landed at the old address 123.
    drive(1'b1, 1'b0, 10'h123, 10'h000, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    n_tests++;
    if (bus.abyp !== 1'b1 || bus.abyp_data !== 32'h5555_AAAA) begin
      n_fail++;
      $display("FAIL coll_fwd: got abyp=%b data=%h expected 1/5555aaaa",
               bus.abyp, bus.abyp_data);
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid_write();
    drive(1'b1, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b1, 10'h000, 10'h000, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    step();
    drive(1'b0, 1'b1, 10'h000, 10'h000, 1'b0, 1'b1, 32'h8765_4321, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    n_tests++;
    if (bus.awp !== 1'b1 || bus.wadr !== 10'h000 || bus.abyp !== 1'b0 ||
        bus.abyp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_regs: got awp=%b wadr=%h abyp=%b data=%h expected 1/000/0/0",
               bus.awp, bus.wadr, bus.abyp, bus.abyp_data);
    end
    bus.state_write = 1'b0;
    #1;
    n_tests++;
    if (bus.awp !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_awp: got awp=%b expected 0", bus.awp);
    end
    @(posedge clk);
    #1;
    idle();
    reset = 1'b1;
    model_reset();
    drive(1'b1, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    n_tests++;
    if (bus.abyp !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_stale: got abyp=%b expected 0", bus.abyp);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] a;
    for (int i = 0; i < 24; i++) begin
      a = 10'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: drive(1'b1, 1'b0, a, 10'($urandom_range(0, 3)), 1'b0, 1'b0, 32'h0, 1'b0);
        1: drive(1'b0, 1'b1, a, 10'h000, 1'b0, 1'b1, 32'($urandom), 1'($urandom));
        2: drive(1'b1, 1'b0, a, 10'($urandom_range(0, 3)), 1'b0, 1'b0, 32'h0, 1'($urandom));
        default: drive(1'b0, 1'b0, a, 10'h000, 1'b0, 1'b0, 32'h0, 1'($urandom));
      endcase
      step();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    idle();
    #2;
    test_reset();
    test_addr_select();
    test_m_dest();
    test_forward();
    test_inval();
    test_collision();
    test_reset_mid_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/amem_ctl_byp.md
Name: amem_ctl_byp

Overview:
- Parametrised A-memory control for the CADR-style datapath.
- Derives the A-memory read/write addresses and strobes from the instruction register and the sequencer state strobes.
- Unlike the fixed 10-bit A control, it has configurable address/field geometry and a last-write bypass register.
- The bypass forwards data written during STATE_WRITE to a following read of the same location, hiding the synchronous-RAM read-after-write hazard.

Parameters:
- AW, 10, A-memory address width.
- MW, 5, M-memory destination address width; must be < AW.
- IRW, 49, instruction register width.
- DW, 32, A-memory data width.
- ASRC_LSB, 32, LSB of the A-source field in ir; field width is AW.
- ADST_LSB, 14, LSB of the destination field in ir; field width is AW.
- BYPASS, 1, 1 = bypass logic present; 0 = abyp tied 0 and abyp_data tied 0.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-low; 0 forces all registers to reset values immediately.
- state_decode, input, 1, sequencer DECODE state strobe.
- state_write, input, 1, sequencer WRITE state strobe.
- ir, input, IRW, instruction register.
- dest, input, 1, instruction writes A/M memory.
- destm, input, 1, destination is M memory (short address).
- l, input, DW, write data presented during state_write.
- inval, input, 1, invalidate bypass register (external A-memory load).
- aadr, output, AW, A-memory address.
- wadr, output, AW, latched write address.
- arp, output, 1, A-memory read pulse.
- awp, output, 1, A-memory write pulse.
- abyp, output, 1, registered select: use abyp_data instead of the RAM output.
- abyp_data, output, DW, registered forwarded data.

Behaviour:
- Reset (reset=0, async) clears: wadr=0, lw_addr=0, lw_data=0, lw_valid=0, abyp=0, abyp_data=0.
- Fields:
  - src = ir[ASRC_LSB+AW-1:ASRC_LSB].
  - dst = destm ? {zero-extend, ir[ADST_LSB+MW-1:ADST_LSB]} : ir[ADST_LSB+AW-1:ADST_LSB].
- wadr register:
  - On a clock edge with state_decode=1: wadr <= dst.
  - Otherwise holds.
- Combinational outputs:
  - awp = dest & state_write.
  - arp = state_decode & ~state_write.
  - aadr = state_write ? wadr : src. Write address wins when both strobes are high.
- Last-write register:
  - On an edge with awp=1: lw_addr <= wadr, lw_data <= l, lw_valid <= 1.
  - Else if inval=1: lw_valid <= 0.
  - awp has priority over inval in the same cycle.
- Bypass (BYPASS=1), one-cycle latency, aligned with the synchronous RAM read:
  - On an edge with arp=1:
    - abyp <= lw_valid & (src == lw_addr).
    - abyp_data <= lw_data.
    - Uses pre-edge register values.
  - On an edge with arp=0: abyp <= 0; abyp_data holds.
  - An inval on the same edge as arp does not affect that comparison; lw_valid is sampled before the update.
- Both strobes high together (sequencer violation):
  - No read pulse; write proceeds.
  - wadr still captures dst.
  - abyp <= 0.
- Address wrap: none. All addresses are exact AW-bit compares; M-destination upper bits are always 0.
- Reset mid-write: awp drops combinationally with state_write; registers clear asynchronously; lw_valid=0, so no stale forward after reset.

Test Plan:
- Reset: reset=0 with strobes toggling -> wadr=0, abyp=0, abyp_data=0; awp follows dest&state_write; after release, the first decode with src=0 gives abyp=0.
- Address select: decode with ir[41:32]=10'h155, ir[23:14]=10'h2A3, destm=0 -> aadr=10'h155, arp=1; next edge wadr=10'h2A3; during write aadr=10'h2A3, awp=dest.
- M destination: destm=1, ir[23:14]=10'h3F7 -> wadr=10'h017.
- Forwarding: write wadr=10'h040, l=32'hDEADBEEF; then decode src=10'h040 -> one cycle later abyp=1, abyp_data=32'hDEADBEEF. Decode src=10'h041 -> abyp=0.
- Invalidate priority: inval=1 alone, then decode src=10'h040 -> abyp=0. inval=1 together with awp -> lw_valid stays 1 and the next matching decode forwards.
- Strobe collision: state_decode=state_write=1, dest=1 -> arp=0, awp=1, aadr=old wadr; next edge abyp=0 and wadr=new dst.
